// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: bus registers, TX/RX FIFOs and the byte-level
// start_tx/tx_done and rx_available/rx_clear handshakes towards the UART core.
module uart_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       start_tx,
  output logic [7:0] tx_value,
  input  logic       tx_done,
  input  logic       rx_available,
  input  logic [7:0] rx_value,
  output logic       rx_clear
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);

  localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_SEND = 2'd1;
  localparam logic [1:0] T_REL  = 2'd2;

  localparam logic [0:0] R_WAIT = 1'b0;
  localparam logic [0:0] R_ACK  = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW:0] tx_rptr_q, tx_rptr_d;

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
  logic [RX_AW:0] rx_rptr_q, rx_rptr_d;

  logic [1:0] tx_state_q, tx_state_d;
  logic       start_tx_q, start_tx_d;
  logic [7:0] tx_value_q, tx_value_d;

  logic [0:0] rx_state_q, rx_state_d;
  logic       rx_clear_q, rx_clear_d;

  logic [6:0] ctrl_q, ctrl_d;
  logic       tx_drop_q, tx_drop_d;
  logic       rx_overrun_q, rx_overrun_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic data_wr, data_rd, status_wr, ctrl_wr, flush;

  assign data_wr   = wr_en && (addr == ADDR_DATA);
  assign data_rd   = rd_en && (addr == ADDR_DATA);
  assign status_wr = wr_en && (addr == ADDR_STATUS);
  assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
  assign flush     = ctrl_wr && wdata[7];

  // ---------------------------------------------------------------------------
  // FIFO flags
  // ---------------------------------------------------------------------------
  logic tx_full, tx_empty, rx_full, rx_empty, rx_nonempty, tx_busy;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_nonempty = ~rx_empty;
  assign tx_busy     = (tx_state_q != T_IDLE) || ~tx_empty;

  // ---------------------------------------------------------------------------
  // Push / pop strobes
  // ---------------------------------------------------------------------------
  logic tx_push, tx_pop, rx_push, rx_pop, rx_attempt;

  assign tx_push    = data_wr && !tx_full;
  assign rx_pop     = data_rd && !rx_empty && !flush;
  assign rx_attempt = (rx_state_q == R_WAIT) && rx_available;
  // A same-cycle bus pop frees the slot for the incoming byte.
  assign rx_push    = rx_attempt && (!rx_full || rx_pop) && !flush;

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    start_tx_d = start_tx_q;
    tx_value_d = tx_value_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty && !flush) begin
          tx_pop     = 1'b1;
          tx_value_d = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
          start_tx_d = 1'b1;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_done) begin
          start_tx_d = 1'b0;
          tx_state_d = T_REL;
        end
      end
      T_REL: begin
        start_tx_d = 1'b0;
        if (!tx_done) tx_state_d = T_IDLE;
      end
      default: begin
        start_tx_d = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = rx_clear_q;
    case (rx_state_q)
      R_WAIT: begin
        rx_clear_d = 1'b0;
        if (rx_available) begin
          rx_clear_d = 1'b1;
          rx_state_d = R_ACK;
        end
      end
      R_ACK: begin
        if (!rx_available) begin
          rx_clear_d = 1'b0;
          rx_state_d = R_WAIT;
        end
      end
      default: begin
        rx_clear_d = 1'b0;
        rx_state_d = R_WAIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, flags and control
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + TX_PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_PTR_ONE;
      if (rx_push) rx_wptr_d = rx_wptr_q + RX_PTR_ONE;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_PTR_ONE;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = wdata[6:0];
    // Set events take priority over a same-cycle write-one-to-clear.
    tx_drop_d    = (tx_drop_q && !(status_wr && wdata[6])) || (data_wr && tx_full);
    rx_overrun_d = (rx_overrun_q && !(status_wr && wdata[4])) ||
                   (rx_attempt && rx_full && !rx_pop && !flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_state_q   <= T_IDLE;
      start_tx_q   <= 1'b0;
      tx_value_q   <= 8'h00;
      rx_state_q   <= R_WAIT;
      rx_clear_q   <= 1'b0;
      ctrl_q       <= 7'h00;
      tx_drop_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      tx_state_q   <= tx_state_d;
      start_tx_q   <= start_tx_d;
      tx_value_q   <= tx_value_d;
      rx_state_q   <= rx_state_d;
      rx_clear_q   <= rx_clear_d;
      ctrl_q       <= ctrl_d;
      tx_drop_q    <= tx_drop_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && tx_push && !flush) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= wdata;
    if (rst_n && rx_push)           rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_value;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [7:0] status;

  assign status = {1'b0, tx_drop_q, tx_busy, rx_overrun_q, rx_full, rx_nonempty, tx_empty,
                   tx_full};

  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_DATA:   if (!rx_empty) rdata = rx_mem_q[rx_rptr_q[RX_AW-1:0]];
      ADDR_STATUS: rdata = status;
      ADDR_CTRL:   rdata = {1'b0, ctrl_q};
      default:     rdata = 8'h00;
    endcase
  end

  assign irq      = (ctrl_q[0] && rx_nonempty) || (ctrl_q[1] && !tx_busy);
  assign start_tx = start_tx_q;
  assign tx_value = tx_value_q;
  assign rx_clear = rx_clear_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a TX core model and TX/RX byte scoreboards.
module tb_uart_ctrl;

  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [1:0] addr;
  logic [7:0] wdata, rdata;
  logic       irq, start_tx;
  logic [7:0] tx_value;
  logic       tx_done, rx_available;
  logic [7:0] rx_value;
  logic       rx_clear;

  int n_assert = 0;
  int n_fail   = 0;
  int tx_sent  = 0;
  bit tx_stall = 1'b0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .irq          (irq),
    .start_tx     (start_tx),
    .tx_value     (tx_value),
    .tx_done      (tx_done),
    .rx_available (rx_available),
    .rx_value     (rx_value),
    .rx_clear     (rx_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1ns after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
    rd_en = 1'b1; addr = a;
    #1 check(tag, rdata, exp);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic data_read_check(input string tag);
    logic [7:0] e;
    e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
    read_check(2'd0, e, tag);
  endtask

  task automatic tx_write(input logic [7:0] d, input bit accept);
    if (accept) exp_tx.push_back(d);
    bus_write(2'd0, d);
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    bit got = 1'b0;
    if (exp_rx.size() < RXD) exp_rx.push_back(b);
    rx_value = b; rx_available = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (rx_clear === 1'b1) got = 1'b1;
    end
    check("rx_clear_high", {7'h0, rx_clear}, 8'h01);
    rx_available = 1'b0;
    @(posedge clk); #1;
    check("rx_clear_low", {7'h0, rx_clear}, 8'h00);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 2000 && tx_sent < n; i++) begin
      @(posedge clk); #1;
    end
    check("tx_sent_count", tx_sent[7:0], n[7:0]);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Core TX model: tx_done 20 cycles after start_tx rises, dropped a cycle after it falls.
  initial begin
    logic [7:0] v;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start_tx === 1'b1) begin
        v = tx_value;
        n_assert++;
        assert (exp_tx.size() != 0)
        else begin
          n_fail++;
          $error("FAIL tx_extra: observed byte %02h expected none", v);
        end
        if (exp_tx.size() != 0) check("tx_value", v, exp_tx.pop_front());
        while (tx_stall) begin
          @(posedge clk); #1;
        end
        repeat (19) @(posedge clk);
        #1;
        check("tx_value_hold", tx_value, v);
        tx_done = 1'b1;
        @(posedge clk); #1;
        check("start_tx_drop", {7'h0, start_tx}, 8'h00);
        @(posedge clk); #1;
        tx_done = 1'b0;
        tx_sent++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wdata = 8'h00;
    rx_available = 1'b0; rx_value = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_start_tx", {7'h0, start_tx}, 8'h00);
    check("rst_rx_clear", {7'h0, rx_clear}, 8'h00);
    check("rst_irq", {7'h0, irq}, 8'h00);
    check("rst_tx_value", tx_value, 8'h00);
    read_check(2'd1, 8'h02, "rst_status");
    read_check(2'd2, 8'h00, "rst_ctrl");

    // Two bytes through the TX path
    tx_write(8'h55, 1'b1);
    tx_write(8'hA3, 1'b1);
    read_check(2'd1, 8'h20, "tx_busy_status");
    wait_tx(2);
    read_check(2'd1, 8'h02, "tx_idle_status");

    // Overfill the TX FIFO with the core stalled: one byte in flight, four queued
    tx_stall = 1'b1;
    for (int i = 0; i < 6; i++) tx_write(8'h10 + 8'(i), i < 5);
    read_check(2'd1, 8'h61, "tx_full_drop_status");
    bus_write(2'd1, 8'h40);
    read_check(2'd1, 8'h21, "tx_drop_cleared");
    tx_stall = 1'b0;
    wait_tx(7);
    read_check(2'd1, 8'h02, "tx_drained_status");

    // RX overrun: five bytes into a four-entry FIFO
    for (int i = 0; i < 5; i++) rx_deliver(8'h31 + 8'(i));
    read_check(2'd1, 8'h1E, "rx_full_overrun_status");
    for (int i = 0; i < 5; i++) data_read_check("rx_data");
    read_check(2'd1, 8'h12, "rx_empty_overrun_status");
    bus_write(2'd1, 8'h10);
    read_check(2'd1, 8'h02, "rx_overrun_cleared");

    // Interrupts and flush
    bus_write(2'd2, 8'h01);
    check("irq_rx_idle", {7'h0, irq}, 8'h00);
    rx_deliver(8'h77);
    check("irq_rx_set", {7'h0, irq}, 8'h01);
    data_read_check("irq_rx_data");
    check("irq_rx_clear", {7'h0, irq}, 8'h00);
    tx_stall = 1'b1;
    for (int i = 0; i < 4; i++) tx_write(8'hC0 + 8'(i), 1'b1);
    bus_write(2'd2, 8'h82);
    repeat (3) void'(exp_tx.pop_back());
    check("irq_busy", {7'h0, irq}, 8'h00);
    read_check(2'd1, 8'h22, "flush_status");
    read_check(2'd2, 8'h02, "ctrl_readback");
    tx_stall = 1'b0;
    wait_tx(8);
    check("irq_txdone", {7'h0, irq}, 8'h01);
    bus_write(2'd2, 8'h00);
    check("irq_off", {7'h0, irq}, 8'h00);

    // Delivery into a full RX FIFO coinciding with a DATA read
    for (int i = 0; i < 4; i++) rx_deliver(8'hA0 + 8'(i));
    read_check(2'd1, 8'h0E, "rx_full_status");
    rx_value = 8'hA4; rx_available = 1'b1; rd_en = 1'b1; addr = 2'd0;
    #1 check("sim_rdata", rdata, exp_rx.pop_front());
    exp_rx.push_back(8'hA4);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("sim_rx_clear", {7'h0, rx_clear}, 8'h01);
    rx_available = 1'b0;
    @(posedge clk); #1;
    read_check(2'd1, 8'h0E, "sim_no_overrun");
    for (int i = 0; i < 4; i++) data_read_check("sim_data");
    read_check(2'd1, 8'h02, "sim_empty_status");

    // Reserved address
    bus_write(2'd3, 8'hFF);
    read_check(2'd3, 8'h00, "addr3_read");
    read_check(2'd2, 8'h00, "addr3_ctrl_untouched");
    read_check(2'd1, 8'h02, "addr3_status_untouched");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
